// File: rtl/display_arbiter_if.sv
// ============================================================================
// Module   : display_arbiter_if
// Brief    : Request/grant and display-data bundle between requesters and arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

interface display_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int HOLD_W = 16
);
  localparam int OW = $clog2(N_REQ);

  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] req_hex;
  logic [16*N_REQ-1:0] req_pwm;
  logic [HOLD_W-1:0]   hold_cycles;
  logic [N_REQ-1:0]    grant;
  logic [OW-1:0]       owner;
  logic                busy;
  logic [15:0]         seg_hex;
  logic [15:0]         diod_pwm;

  modport master (
    output req, req_hex, req_pwm, hold_cycles,
    input  grant, owner, busy, seg_hex, diod_pwm
  );

  modport slave (
    input  req, req_hex, req_pwm, hold_cycles,
    output grant, owner, busy, seg_hex, diod_pwm
  );
endinterface

`default_nettype wire

// File: rtl/display_arbiter.sv
// ============================================================================
// Module   : display_arbiter
// Brief    : Round-robin owner of the shared 7-seg display / PWM LED with hold time
// Revision : 1.0
// ============================================================================
`default_nettype none

module display_arbiter #(
  parameter int          N_REQ       = 4,
  parameter int          HOLD_W      = 16,
  parameter logic [15:0] DEFAULT_HEX = 16'h0000
) (
  input  wire              CLK,
  input  wire              RST,
  display_arbiter_if.slave bus
);
  localparam int OW = $clog2(N_REQ);

  typedef enum logic [0:0] {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic                busy_q, busy_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]       rr_last_q, rr_last_d;
  logic [15:0]         seg_hex_q, seg_hex_d;
  logic [15:0]         diod_pwm_q, diod_pwm_d;

  logic [N_REQ-1:0]    others_w;
  logic [N_REQ-1:0]    mask_w;
  logic [OW-1:0]       win_w;

  // First set bit of mask searching upward from last+1, wrapping.
  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] mask,
                                            input logic [OW-1:0]    last);
    logic [OW-1:0] pick;
    logic [OW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = OW'((int'(last) + i) % N_REQ);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign others_w = bus.req & ~grant_q;
  assign mask_w   = (state_q == OWN) ? others_w : bus.req;
  assign win_w    = rr_pick(mask_w, rr_last_q);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    rr_last_d  = rr_last_q;
    seg_hex_d  = seg_hex_q;
    diod_pwm_d = diod_pwm_q;

    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d    = OWN;
          grant_d    = N_REQ'(1) << win_w;
          owner_d    = win_w;
          busy_d     = 1'b1;
          cnt_d      = '0;
          rr_last_d  = win_w;
          seg_hex_d  = bus.req_hex[{win_w, 4'b0000} +: 16];
          diod_pwm_d = bus.req_pwm[{win_w, 4'b0000} +: 16];
        end
      end
      OWN: begin
        // Release with a waiting requester, or preempt once the hold has elapsed;
        // cnt above a lowered hold_cycles counts as elapsed.
        if ((|others_w) && (!bus.req[owner_q] || (cnt_q >= bus.hold_cycles))) begin
          grant_d    = N_REQ'(1) << win_w;
          owner_d    = win_w;
          cnt_d      = '0;
          rr_last_d  = win_w;
          seg_hex_d  = bus.req_hex[{win_w, 4'b0000} +: 16];
          diod_pwm_d = bus.req_pwm[{win_w, 4'b0000} +: 16];
        end else if (!bus.req[owner_q]) begin
          state_d    = IDLE;
          grant_d    = '0;
          owner_d    = '0;
          busy_d     = 1'b0;
          cnt_d      = '0;
          seg_hex_d  = DEFAULT_HEX;
          diod_pwm_d = 16'h0000;
        end else begin
          cnt_d      = (cnt_q >= bus.hold_cycles) ? bus.hold_cycles : cnt_q + HOLD_W'(1);
          seg_hex_d  = bus.req_hex[{owner_q, 4'b0000} +: 16];
          diod_pwm_d = bus.req_pwm[{owner_q, 4'b0000} +: 16];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      rr_last_q  <= OW'(N_REQ - 1);
      seg_hex_q  <= DEFAULT_HEX;
      diod_pwm_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      rr_last_q  <= rr_last_d;
      seg_hex_q  <= seg_hex_d;
      diod_pwm_q <= diod_pwm_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = busy_q;
  assign bus.seg_hex  = seg_hex_q;
  assign bus.diod_pwm = diod_pwm_q;

endmodule

`default_nettype wire

// File: tb/tb_display_arbiter.sv
// ============================================================================
// Module   : tb_display_arbiter
// Brief    : Directed scenario bench for display_arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_display_arbiter;
  localparam logic [15:0] DEF = 16'hD0D0;

  logic CLK;
  logic RST;
  int   vec_cnt;
  int   miss_cnt;
  logic [38:0] exp_v;
  logic [38:0] obs_w;

  display_arbiter_if #(.N_REQ(4), .HOLD_W(16)) bus ();

  display_arbiter #(.N_REQ(4), .HOLD_W(16), .DEFAULT_HEX(DEF)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {grant, owner, busy, seg_hex, diod_pwm}
  assign obs_w = {bus.grant, bus.owner, bus.busy, bus.seg_hex, bus.diod_pwm};

  localparam logic [38:0] IDLE_V = {4'b0000, 2'd0, 1'b0, DEF, 16'h0000};
  localparam logic [38:0] OWN0_V = {4'b0001, 2'd0, 1'b1, 16'h1234, 16'h0080};
  localparam logic [38:0] OWN1_V = {4'b0010, 2'd1, 1'b1, 16'hAAA1, 16'h0011};
  localparam logic [38:0] OWN2_V = {4'b0100, 2'd2, 1'b1, 16'hBBB2, 16'h0022};
  localparam logic [38:0] OWN3_V = {4'b1000, 2'd3, 1'b1, 16'hCCC3, 16'h0033};

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = 4'b1111;
    RST = 1'b1;
    step();
    step();
    vec_cnt++;
    if (obs_w !== IDLE_V) begin
      miss_cnt++;
      $display("FAIL reset_state got %h exp %h", obs_w, IDLE_V);
    end
    RST = 1'b0;
    bus.req = 4'b0000;
  endtask

  task automatic test_single();
    do_reset();
    bus.hold_cycles = 16'd3;
    bus.req = 4'b0001;
    step();
    vec_cnt++;
    if (obs_w !== OWN0_V) begin
      miss_cnt++;
      $display("FAIL single_grant got %h exp %h", obs_w, OWN0_V);
    end
    bus.req_hex[15:0] = 16'h5678;
    step();
    exp_v = {4'b0001, 2'd0, 1'b1, 16'h5678, 16'h0080};
    vec_cnt++;
    if (obs_w !== exp_v) begin
      miss_cnt++;
      $display("FAIL live_follow got %h exp %h", obs_w, exp_v);
    end
    bus.req_hex[15:0] = 16'h1234;
    for (int i = 0; i < 6; i++) step();
    vec_cnt++;
    if (obs_w !== OWN0_V) begin
      miss_cnt++;
      $display("FAIL sole_keeps got %h exp %h", obs_w, OWN0_V);
    end
    bus.req = 4'b0000;
    step();
    vec_cnt++;
    if (obs_w !== IDLE_V) begin
      miss_cnt++;
      $display("FAIL single_release got %h exp %h", obs_w, IDLE_V);
    end
  endtask

  task automatic test_hold();
    do_reset();
    bus.hold_cycles = 16'd3;
    bus.req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      step();
      vec_cnt++;
      if (obs_w !== OWN0_V) begin
        miss_cnt++;
        $display("FAIL hold_cycle%0d got %h exp %h", i, obs_w, OWN0_V);
      end
    end
    step();
    vec_cnt++;
    if (obs_w !== OWN1_V) begin
      miss_cnt++;
      $display("FAIL hold_preempt got %h exp %h", obs_w, OWN1_V);
    end
  endtask

  task automatic test_handoff();
    do_reset();
    bus.hold_cycles = 16'd3;
    bus.req = 4'b0001;
    step();
    bus.req = 4'b0101;
    step();
    vec_cnt++;
    if (obs_w !== OWN0_V) begin
      miss_cnt++;
      $display("FAIL handoff_hold got %h exp %h", obs_w, OWN0_V);
    end
    bus.req = 4'b0100;
    step();
    vec_cnt++;
    if (obs_w !== OWN2_V) begin
      miss_cnt++;
      $display("FAIL handoff_switch got %h exp %h", obs_w, OWN2_V);
    end
    bus.req = 4'b0000;
    step();
    vec_cnt++;
    if (obs_w !== IDLE_V) begin
      miss_cnt++;
      $display("FAIL handoff_idle got %h exp %h", obs_w, IDLE_V);
    end
  endtask

  task automatic test_rotate();
    logic [38:0] seq [5];
    seq[0] = OWN0_V; seq[1] = OWN1_V; seq[2] = OWN2_V; seq[3] = OWN3_V; seq[4] = OWN0_V;
    do_reset();
    bus.hold_cycles = 16'd0;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      vec_cnt++;
      if (obs_w !== seq[i]) begin
        miss_cnt++;
        $display("FAIL rotate%0d got %h exp %h", i, obs_w, seq[i]);
      end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_hold_change();
    do_reset();
    bus.hold_cycles = 16'd5;
    bus.req = 4'b0001;
    for (int i = 0; i < 4; i++) step();
    vec_cnt++;
    if (obs_w !== OWN0_V) begin
      miss_cnt++;
      $display("FAIL holdchg_own got %h exp %h", obs_w, OWN0_V);
    end
    bus.hold_cycles = 16'd1;
    bus.req = 4'b0011;
    step();
    vec_cnt++;
    if (obs_w !== OWN1_V) begin
      miss_cnt++;
      $display("FAIL holdchg_preempt got %h exp %h", obs_w, OWN1_V);
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_rst_mid();
    do_reset();
    bus.hold_cycles = 16'd3;
    bus.req = 4'b0100;
    step();
    vec_cnt++;
    if (obs_w !== OWN2_V) begin
      miss_cnt++;
      $display("FAIL rstmid_own2 got %h exp %h", obs_w, OWN2_V);
    end
    RST = 1'b1;
    bus.req = 4'b1111;
    step();
    vec_cnt++;
    if (obs_w !== IDLE_V) begin
      miss_cnt++;
      $display("FAIL rstmid_reset got %h exp %h", obs_w, IDLE_V);
    end
    RST = 1'b0;
    step();
    vec_cnt++;
    if (obs_w !== OWN0_V) begin
      miss_cnt++;
      $display("FAIL rstmid_first got %h exp %h", obs_w, OWN0_V);
    end
    bus.req = 4'b0000;
  endtask

  initial begin
    vec_cnt              = 0;
    miss_cnt             = 0;
    RST                  = 1'b1;
    bus.req              = 4'b0000;
    bus.hold_cycles      = 16'd3;
    bus.req_hex          = {16'hCCC3, 16'hBBB2, 16'hAAA1, 16'h1234};
    bus.req_pwm          = {16'h0033, 16'h0022, 16'h0011, 16'h0080};

    test_reset();
    test_single();
    test_hold();
    test_handoff();
    test_rotate();
    test_hold_change();
    test_rst_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

`default_nettype wire
